dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- FIFO write buffer between the MEM-stage store path and the data memory (DM).
- Stores retire into the buffer in one cycle and drain to DM one per cycle whenever the single DM address port is not needed by a load.
- Loads that hit a pending store's word are stalled until that store has drained, so DM reads are always coherent.
- Owns the DM port: it drives DM's address, write data, write enable, mode and PC inputs.

Parameters:
DEPTH, 4, number of buffer entries; power of two, at least 2.
CW, 3, width of the occupancy counter; must equal log2(DEPTH)+1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
st_valid  input  1  MEM-stage store request
st_addr  input  32  store byte address
st_data  input  32  store data, unaligned as issued by the core
st_byte  input  1  0 = word (sw), 1 = byte (sb)
st_pc  input  32  PC of the store instruction
st_ready  output  1  buffer can accept a store this cycle (not full)
ld_req  input  1  MEM-stage load request
ld_addr  input  32  load byte address
ld_byte  input  1  0 = lw, 1 = lb
ld_stall  output  1  load must be held by the pipeline this cycle
ld_data  output  32  load result; valid when ld_req=1 and ld_stall=0
empty  output  1  no pending stores
dm_addr  output  32  to DM memAddr
dm_wd  output  32  to DM memWD
dm_we  output  1  to DM memWE
dm_mode  output  1  to DM mode
dm_pc  output  32  to DM PC
dm_rd  input  32  from DM memRD

Behaviour:
- Storage: DEPTH entries of {addr, data, byte, pc}, plus head pointer, tail pointer and count.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Reset: pointers=0, count=0. Outputs after reset: st_ready=1, empty=1, dm_we=0, ld_stall=0. Entry contents are don't-care.
- Reset asserted mid-drain discards all pending entries, and dm_we=0 in that cycle.
- Flags: full = (count==DEPTH); empty = (count==0); st_ready = !full. All are derived from registered count only.
- Push: st_valid && !full -> entry written at the tail, tail+1.
  - st_valid && full -> no push, no state change. The core holds the store.
  - No push-through: a store pushed at edge N is first presented to DM in the cycle after edge N.
- Conflict: conflict = ld_req && some valid entry has addr[13:2] == ld_addr[13:2].
  - Only valid entries, head up to tail-1, are compared.
  - Byte lanes are ignored; any match within the same word is a conflict.
- Drain: drain = !empty && (!ld_req || conflict).
  - dm_we = drain.
  - dm_addr/dm_wd/dm_mode/dm_pc come from the head entry when drain=1.
  - At the clock edge with drain=1, head+1.
  - DM performs the write, and its $display, at that same edge.
- Load path: when drain=0, dm_addr=ld_addr, dm_mode=ld_byte, dm_we=0, dm_wd=0, dm_pc=0.
  - ld_data = dm_rd combinationally. The DM read is combinational, so a non-conflicting load completes in 0 extra cycles.
  - ld_stall = conflict. It stays 1 across cycles until the last matching entry has drained. The load is then serviced in the following cycle.
- Simultaneous push and drain: count unchanged, both pointers advance.
  - When full, the push is still refused in that cycle, even though an entry drains.
- st_valid && ld_req together is illegal, because one memory instruction is in MEM per cycle. In that case the store takes priority and ld_stall=1.
- Ordering: strict FIFO. DM sees stores in issue order.
- Alignment: the buffer does no alignment. Addresses and data pass to DM unmodified; DM performs byte-lane placement.
- Core halt: the core waits for empty=1 before ending simulation so that all stores are logged.

Test Plan:
- Reset then idle -> st_ready=1, empty=1, dm_we=0 for 5 cycles, with ld_req=0 and st_valid=0.
- Single sw at 0x0000_0010 with data 0xDEADBEEF, pc 0x3000, then idle.
  - Cycle after push: dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF, dm_pc=0x3000, dm_mode=0.
  - Following cycle: empty=1.
- Fill: 4 sw back-to-back to 0x0,0x4,0x8,0xC with ld_req=1 to 0x100 throughout.
  - No drain during fill; st_ready=0 after the 4th push; 5th store refused.
  - Drop ld_req -> entries drain in order 0x0,0x4,0x8,0xC over 4 cycles.
- Conflict load: sb to 0x21 (data 0x0000AB00) pending, then lb at 0x22.
  - ld_stall=1 and dm_we=1 with dm_addr=0x21 in the first cycle.
  - Next cycle: ld_stall=0, dm_addr=0x22, ld_data = DM's sign-extended byte.
- Non-conflicting load with 2 pending stores to 0x40,0x44: lw from 0x80.
  - ld_stall=0, dm_we=0, dm_addr=0x80, count stays 2.
- Reset asserted with 3 pending entries -> next cycle empty=1, dm_we=0, and no further DM writes occur.

Source files
------------

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: FIFO write buffer between the MEM-stage store path and DM.
// Stores retire here in one cycle and drain one per cycle when DM's single
// port is not needed by a load; loads hitting a pending word are stalled.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   st_*                store request in, st_ready = not full
//   ld_*                load request in, ld_stall / ld_data out
//   empty               no pending stores
//   dm_*                DM port (addr, wd, we, mode, pc out; rd in)
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_byte,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic        ld_byte,
    output logic        ld_stall,
    output logic [31:0] ld_data,
    output logic        empty,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    output logic        dm_mode,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic            full;
    logic            push;
    logic            drain;
    logic            conflict;
    logic            hit;
    logic [PW-1:0]   idx;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign push     = st_valid && !full;

    // Compare the load word against every occupied slot, walking from head
    // so that only entries head..tail-1 take part.
    always_comb begin
        hit = 1'b0;
        idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (mem_q[idx].addr[13:2] == ld_addr[13:2]))
                hit = 1'b1;
        end
    end

    assign conflict = ld_req && hit;

    // Reset gates the drain so no write reaches DM in the reset cycle.
    assign drain = !reset && !empty && (!ld_req || conflict);

    // A load issued alongside a store is held; the store wins the cycle.
    assign ld_stall = conflict || (ld_req && st_valid);
    assign ld_data  = dm_rd;

    always_comb begin
        dm_addr = ld_addr;
        dm_mode = ld_byte;
        dm_we   = 1'b0;
        dm_wd   = '0;
        dm_pc   = '0;
        if (drain) begin
            dm_addr = mem_q[head_q].addr;
            dm_mode = mem_q[head_q].is_byte;
            dm_we   = 1'b1;
            dm_wd   = mem_q[head_q].data;
            dm_pc   = mem_q[head_q].pc;
        end
    end

    // Entry payload carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q].addr    <= st_addr;
            mem_q[tail_q].data    <= st_data;
            mem_q[tail_q].is_byte <= st_byte;
            mem_q[tail_q].pc      <= st_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                tail_q <= tail_q + PW'(1);
            if (drain)
                head_q <= head_q + PW'(1);
            case ({push, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed bench for dm_store_buffer with a small
// behavioural DM (combinational read, byte lanes, sign-extended lb).
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        ld_stall;
    logic [31:0] ld_data;
    logic        empty;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic        dm_mode;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_snap;

    logic [31:0] dmem [64];
    logic [31:0] rword;
    logic [7:0]  rbyte;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_byte(st_byte), .st_pc(st_pc), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .ld_stall(ld_stall), .ld_data(ld_data), .empty(empty),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we),
        .dm_mode(dm_mode), .dm_pc(dm_pc), .dm_rd(dm_rd)
    );

    always_comb begin
        rword = dmem[dm_addr[7:2]];
        rbyte = rword[8*dm_addr[1:0] +: 8];
        dm_rd = dm_mode ? {{24{rbyte[7]}}, rbyte} : rword;
    end

    always @(posedge clk) begin
        if (dm_we) begin
            wr_cnt <= wr_cnt + 1;
            if (dm_mode)
                dmem[dm_addr[7:2]][8*dm_addr[1:0] +: 8] <= dm_wd[7:0];
            else
                dmem[dm_addr[7:2]] <= dm_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_st(input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic b,
                          input logic [31:0] pc);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_byte  = b;
        st_pc    = pc;
    endtask

    task automatic set_ld(input logic r, input logic [31:0] a, input logic b);
        ld_req  = r;
        ld_addr = a;
        ld_byte = b;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
        dmem[8]  = 32'h0080_5500;
        dmem[32] = 32'h1234_5678;
        reset = 1'b1;
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        set_ld(1'b0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // reset then idle
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("idle st_ready", 32'(st_ready), 32'd1);
            chk("idle empty", 32'(empty), 32'd1);
            chk("idle dm_we", 32'(dm_we), 32'd0);
            chk("idle ld_stall", 32'(ld_stall), 32'd0);
            next_cycle();
        end

        // single sw, no push-through
        set_st(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h3000);
        sample();
        chk("sw same-cycle dm_we", 32'(dm_we), 32'd0);
        next_cycle();
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        sample();
        chk("sw dm_we", 32'(dm_we), 32'd1);
        chk("sw dm_addr", dm_addr, 32'h10);
        chk("sw dm_wd", dm_wd, 32'hDEAD_BEEF);
        chk("sw dm_pc", dm_pc, 32'h3000);
        chk("sw dm_mode", 32'(dm_mode), 32'd0);
        next_cycle();
        sample();
        chk("sw empty after", 32'(empty), 32'd1);
        chk("sw mem", dmem[4], 32'hDEAD_BEEF);

        // fill with a non-conflicting load held throughout
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_st(1'b1, 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0,
                   32'h4000 + 32'(4 * k));
            set_ld(1'b1, 32'h100, 1'b0);
            sample();
            chk("fill dm_we", 32'(dm_we), 32'd0);
            chk("fill st_ready", 32'(st_ready), 32'd1);
        end
        next_cycle();
        set_st(1'b1, 32'h50, 32'hBAD0_BAD0, 1'b0, 32'h4010);
        sample();
        chk("full st_ready", 32'(st_ready), 32'd0);
        chk("full dm_we", 32'(dm_we), 32'd0);
        chk("full dm_addr is load", dm_addr, 32'h100);
        next_cycle();
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        set_ld(1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("drain dm_we", 32'(dm_we), 32'd1);
            chk("drain dm_addr", dm_addr, 32'(4 * k));
            chk("drain dm_wd", dm_wd, 32'hA000_0000 + 32'(k));
            next_cycle();
        end
        sample();
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain no 5th", 32'(dm_we), 32'd0);

        // conflicting lb behind a pending sb
        next_cycle();
        set_st(1'b1, 32'h21, 32'h0000_AB00, 1'b1, 32'h3010);
        next_cycle();
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        set_ld(1'b1, 32'h22, 1'b1);
        sample();
        chk("conf ld_stall", 32'(ld_stall), 32'd1);
        chk("conf dm_we", 32'(dm_we), 32'd1);
        chk("conf dm_addr", dm_addr, 32'h21);
        chk("conf dm_mode", 32'(dm_mode), 32'd1);
        next_cycle();
        sample();
        chk("conf2 ld_stall", 32'(ld_stall), 32'd0);
        chk("conf2 dm_we", 32'(dm_we), 32'd0);
        chk("conf2 dm_addr", dm_addr, 32'h22);
        chk("conf2 ld_data", ld_data, 32'hFFFF_FF80);
        chk("conf2 mem", dmem[8], 32'h0080_0000);

        // non-conflicting lw with two pending stores
        next_cycle();
        set_st(1'b1, 32'h40, 32'h1111_1111, 1'b0, 32'h3020);
        set_ld(1'b1, 32'h80, 1'b0);
        next_cycle();
        set_st(1'b1, 32'h44, 32'h2222_2222, 1'b0, 32'h3024);
        next_cycle();
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        sample();
        chk("lw ld_stall", 32'(ld_stall), 32'd0);
        chk("lw dm_we", 32'(dm_we), 32'd0);
        chk("lw dm_addr", dm_addr, 32'h80);
        chk("lw ld_data", ld_data, 32'h1234_5678);
        next_cycle();
        sample();
        chk("lw still pending", 32'(empty), 32'd0);
        chk("lw st_ready", 32'(st_ready), 32'd1);

        // third entry, then reset mid-drain
        next_cycle();
        set_st(1'b1, 32'h48, 32'h3333_3333, 1'b0, 32'h3028);
        next_cycle();
        set_st(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        set_ld(1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        sample();
        chk("rst dm_we", 32'(dm_we), 32'd0);
        wr_snap = wr_cnt;
        next_cycle();
        reset = 1'b0;
        sample();
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst dm_we after", 32'(dm_we), 32'd0);
        next_cycle();
        next_cycle();
        sample();
        chk("rst no writes", 32'(wr_cnt), 32'(wr_snap));
        chk("rst mem 0x40", dmem[16], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
